// File: rtl/ibex_bp_resolve_ctrl.sv
// rtl/ibex_bp_resolve_ctrl.sv - branch prediction resolve queue and fetch redirect control
// Optional statistics counters are enabled with `define IBEX_BP_RESOLVE_STATS_EN.
module ibex_bp_resolve_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        predict_valid_i,
  input  logic        predict_taken_i,
  input  logic [31:0] predict_npc_i,
  output logic        predict_ready_o,
  input  logic        resolve_valid_i,
  input  logic        resolve_taken_i,
  input  logic [31:0] resolve_npc_i,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i,
  output logic        flush_o,
`ifdef IBEX_BP_RESOLVE_STATS_EN
  output logic [31:0] stat_resolved_o,
  output logic [31:0] stat_mispredict_o,
`endif
  output logic        resolve_err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH-1:0]  taken_q;
  logic [31:0]       npc_q [DEPTH];
  logic [31:0]       redirect_pc_q;
  logic              flush_q, err_q;

  logic run, full, empty, push_en, store_en, resolve_acc, mispredict, err_d;
  logic        head_taken;
  logic [31:0] head_npc;

  assign run        = (state_q == RUN);
  assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty      = (wptr_q == rptr_q);
  assign head_taken = taken_q[rptr_q[AW-1:0]];
  assign head_npc   = npc_q[rptr_q[AW-1:0]];

  assign push_en     = predict_valid_i & run & ~full;
  assign resolve_acc = resolve_valid_i & run & ~empty;
  assign mispredict  = resolve_acc &
                       ((head_taken != resolve_taken_i) | (head_npc != resolve_npc_i));
  assign err_d       = resolve_valid_i & run & empty;
  // A mispredict invalidates everything younger, including a push arriving in the same cycle.
  assign store_en    = push_en & ~mispredict;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (mispredict) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (store_en)    wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
      if (resolve_acc) rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (store_en) begin
      taken_q[wptr_q[AW-1:0]] <= predict_taken_i;
      npc_q[wptr_q[AW-1:0]]   <= predict_npc_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RUN;
      wptr_q        <= '0;
      rptr_q        <= '0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      flush_q <= mispredict;
      err_q   <= err_d;
      if (mispredict) redirect_pc_q <= resolve_npc_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mispredict)       state_d = REDIRECT;
      REDIRECT: if (redirect_ready_i) state_d = RUN;
      default:                        state_d = RUN;
    endcase
  end

  always_comb begin
    predict_ready_o  = run & ~full;
    redirect_valid_o = (state_q == REDIRECT);
    redirect_pc_o    = redirect_pc_q;
    flush_o          = flush_q;
    resolve_err_o    = err_q;
  end

`ifdef IBEX_BP_RESOLVE_STATS_EN
  logic [31:0] stat_resolved_q, stat_mispredict_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_resolved_q   <= '0;
      stat_mispredict_q <= '0;
    end else begin
      if (resolve_acc && (stat_resolved_q != '1))  stat_resolved_q   <= stat_resolved_q + 32'd1;
      if (mispredict && (stat_mispredict_q != '1)) stat_mispredict_q <= stat_mispredict_q + 32'd1;
    end
  end

  assign stat_resolved_o   = stat_resolved_q;
  assign stat_mispredict_o = stat_mispredict_q;
`endif

endmodule

// File: tb/tb_ibex_bp_resolve_ctrl.sv
// tb/tb_ibex_bp_resolve_ctrl.sv - directed and random checks against a queue-based reference model
module tb_ibex_bp_resolve_ctrl;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        predict_valid_i, predict_taken_i;
  logic [31:0] predict_npc_i;
  logic        predict_ready_o;
  logic        resolve_valid_i, resolve_taken_i;
  logic [31:0] resolve_npc_i;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;
  logic        flush_o, resolve_err_o;
`ifdef IBEX_BP_RESOLVE_STATS_EN
  logic [31:0] stat_resolved_o, stat_mispredict_o;
`endif

  always #5 clk_i = ~clk_i;

  ibex_bp_resolve_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .predict_valid_i  (predict_valid_i),
    .predict_taken_i  (predict_taken_i),
    .predict_npc_i    (predict_npc_i),
    .predict_ready_o  (predict_ready_o),
    .resolve_valid_i  (resolve_valid_i),
    .resolve_taken_i  (resolve_taken_i),
    .resolve_npc_i    (resolve_npc_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i),
    .flush_o          (flush_o),
`ifdef IBEX_BP_RESOLVE_STATS_EN
    .stat_resolved_o  (stat_resolved_o),
    .stat_mispredict_o(stat_mispredict_o),
`endif
    .resolve_err_o    (resolve_err_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic        taken;
    logic [31:0] npc;
  } pred_t;

  pred_t       mq[$];
  bit          m_redir;
  logic [31:0] m_pc;
  bit          m_flush, m_err;
  int          m_res, m_mis;

  task automatic model_reset();
    mq.delete();
    m_redir = 0;
    m_pc    = '0;
    m_flush = 0;
    m_err   = 0;
    m_res   = 0;
    m_mis   = 0;
  endtask

  task automatic compare_outputs(input string tag);
    check_eq({tag, ":ready"},    {31'd0, predict_ready_o},  {31'd0, (!m_redir && mq.size() < DEPTH)});
    check_eq({tag, ":redir_v"},  {31'd0, redirect_valid_o}, {31'd0, m_redir});
    check_eq({tag, ":redir_pc"}, redirect_pc_o,             m_pc);
    check_eq({tag, ":flush"},    {31'd0, flush_o},          {31'd0, m_flush});
    check_eq({tag, ":err"},      {31'd0, resolve_err_o},    {31'd0, m_err});
`ifdef IBEX_BP_RESOLVE_STATS_EN
    check_eq({tag, ":stat_res"}, stat_resolved_o,   m_res);
    check_eq({tag, ":stat_mis"}, stat_mispredict_o, m_mis);
`endif
  endtask

  // One clock cycle: drive inputs, check the visible state, advance the model, cross the edge.
  task automatic step(input string tag, input bit pv, input bit pt, input logic [31:0] pn,
                      input bit rv, input bit rt, input logic [31:0] rn, input bit rr);
    bit    push, nflush, nerr;
    pred_t head;
    predict_valid_i  = pv;
    predict_taken_i  = pt;
    predict_npc_i    = pn;
    resolve_valid_i  = rv;
    resolve_taken_i  = rt;
    resolve_npc_i    = rn;
    redirect_ready_i = rr;
    compare_outputs(tag);
    nflush = 0;
    nerr   = 0;
    if (!m_redir) begin
      push = pv && (mq.size() < DEPTH);
      if (rv) begin
        if (mq.size() == 0) nerr = 1;
        else begin
          head = mq.pop_front();
          m_res++;
          if (head.taken != rt || head.npc != rn) begin
            m_mis++;
            mq.delete();
            m_redir = 1;
            m_pc    = rn;
            nflush  = 1;
            push    = 0;
          end
        end
      end
      if (push) mq.push_back({pt, pn});
    end else if (rr) begin
      m_redir = 0;
    end
    m_flush = nflush;
    m_err   = nerr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input string tag, input bit rr);
    step(tag, 0, 0, 32'h0, 0, 0, 32'h0, rr);
  endtask

  initial begin
    rst_ni = 1'b0;
    predict_valid_i = 0; predict_taken_i = 0; predict_npc_i = '0;
    resolve_valid_i = 0; resolve_taken_i = 0; resolve_npc_i = '0;
    redirect_ready_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    compare_outputs("reset");
    rst_ni = 1'b1;

    // correct prediction pops silently, then a resolve on the empty queue errors
    step("s1_push", 1, 1, 32'h100, 0, 0, 32'h0, 0);
    step("s1_res",  0, 0, 32'h0,   1, 1, 32'h100, 0);
    step("s1_err",  0, 0, 32'h0,   1, 0, 32'h44, 0);
    idle("s1_errpulse", 0);
    idle("s1_errgone", 0);

    // mispredict with redirect held off for three cycles
    step("s2_push", 1, 0, 32'h204, 0, 0, 32'h0, 0);
    step("s2_mis",  0, 0, 32'h0,   1, 1, 32'h80, 0);
    idle("s2_hold1", 0);
    idle("s2_hold2", 0);
    idle("s2_hold3", 0);
    idle("s2_accept", 1);
    check_eq("s2_pc_const", redirect_pc_o, 32'h80);
    idle("s2_run", 0);

    // fill, overflow attempt, pop restores ready
    for (int i = 0; i < DEPTH; i++) step("s3_fill", 1, i[0], 32'h300 + 4 * i, 0, 0, 32'h0, 0);
    check_eq("s3_full_ready", {31'd0, predict_ready_o}, 32'd0);
    step("s3_extra", 1, 1, 32'hdead, 0, 0, 32'h0, 0);
    step("s3_pop",   0, 0, 32'h0, 1, 0, 32'h300, 0);
    idle("s3_ready", 0);
    for (int i = 1; i < DEPTH; i++) step("s3_drain", 0, 0, 32'h0, 1, i[0], 32'h300 + 4 * i, 0);
    step("s3_empty", 0, 0, 32'h0, 1, 0, 32'h0, 0);
    idle("s3_idle", 0);

    // mispredict with a simultaneous push, then a wrong-path resolve in REDIRECT
    for (int i = 0; i < 3; i++) step("s4_fill", 1, 1, 32'h400 + 4 * i, 0, 0, 32'h0, 0);
    step("s4_mis",    1, 1, 32'h500, 1, 0, 32'h404, 0);
    step("s4_wrong",  0, 0, 32'h0,   1, 1, 32'h999, 0);
    idle("s4_accept", 1);
    step("s4_emptyq", 0, 0, 32'h0,   1, 1, 32'h400, 0);
    idle("s4_idle", 0);

    // asynchronous reset in the middle of a redirect
    step("s5_push", 1, 0, 32'h600, 0, 0, 32'h0, 0);
    step("s5_mis",  0, 0, 32'h0,   1, 1, 32'h700, 0);
    idle("s5_redir", 0);
    #3;
    rst_ni = 1'b0;
    #1;
    model_reset();
    compare_outputs("s5_async");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle("s5_after", 1);

    // three resolves, one of them wrong
    for (int i = 0; i < 3; i++) step("s6_fill", 1, 0, 32'h800 + 4 * i, 0, 0, 32'h0, 0);
    step("s6_r0", 0, 0, 32'h0, 1, 0, 32'h800, 0);
    step("s6_r1", 0, 0, 32'h0, 1, 0, 32'h804, 0);
    step("s6_r2", 0, 0, 32'h0, 1, 1, 32'h808, 1);
    idle("s6_accept", 1);
`ifdef IBEX_BP_RESOLVE_STATS_EN
    check_eq("s6_stat_res", stat_resolved_o, 32'd3);
    check_eq("s6_stat_mis", stat_mispredict_o, 32'd1);
`endif

    for (int n = 0; n < 400; n++) begin
      bit          pv, pt, rv, rt, rr;
      logic [31:0] pn, rn;
      pv = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      pn = 32'h100 + 32'($urandom_range(0, 3)) * 4;
      rv = ($urandom_range(0, 2) == 0);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt = mq[0].taken;
        rn = mq[0].npc;
      end else begin
        rt = 1'($urandom_range(0, 1));
        rn = 32'h100 + 32'($urandom_range(0, 3)) * 4;
      end
      rr = 1'($urandom_range(0, 1));
      step("rand", pv, pt, pn, rv, rt, rn, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
